gpio_debounce: RTL and testbench
================================

Name: gpio_debounce

Overview:
- Input conditioning stage directly upstream of sonata_system gp_i.
- Takes the inverted board switch vector ({user_sw_n, nav_sw_n}, 13 bits) and removes metastability and contact bounce.
- Sync: 2-flop synchroniser per bit. Debounce: per-bit stability counter. Output drives gp_i in place of the raw switch levels.
- Optionally produces edge events and a sticky interrupt for the switches.

Parameters:
- Width, 13, number of input bits.
- DebounceCycles, 500000, stable clk_sys_i cycles required before a level is accepted (10 ms at 50 MHz); legal range 1 to 2^24-1.
- CntWidth, 24, width of each per-bit counter; must satisfy 2^CntWidth > DebounceCycles.

Ports:
- clk_sys_i  input  1  system clock (50 MHz)
- rst_sys_i  input  1  asynchronous, active-high reset
- gpio_i  input  Width  raw asynchronous switch levels (1 = on, already inverted)
- gpio_o  output  Width  debounced levels to sonata_system gp_i
- rise_o  output  Width  one-cycle pulse per bit on accepted 0->1 (macro only)
- fall_o  output  Width  one-cycle pulse per bit on accepted 1->0 (macro only)
- event_o  output  Width  sticky edge-event flags (macro only)
- event_clr_i  input  Width  write-1-to-clear mask for event_o, single-cycle strobe
- irq_en_i  input  Width  per-bit interrupt enable
- irq_o  output  1  OR over (event_o & irq_en_i)

Behaviour:
- Reset is asynchronous and active-high, and takes effect immediately, including mid-count. It clears:
  - sync flops,
  - counters,
  - gpio_o,
  - rise_o, fall_o, event_o and irq_o.
  All outputs reset to 0.
- Sync stage: sync0 <= gpio_i; sync1 <= sync0. Only sync1 feeds the debounce logic.
- Per-bit counter cnt[i], evaluated each cycle:
  - sync1[i] == gpio_o[i]: cnt[i] <= 0. A bounce back to the old level aborts the count.
  - sync1[i] != gpio_o[i] and cnt[i] == DebounceCycles-1: gpio_o[i] <= sync1[i]; cnt[i] <= 0.
  - Otherwise: cnt[i] <= cnt[i] + 1. The counter never wraps because it resets before reaching DebounceCycles.
- Latency: a level first sampled into sync0 on edge 0 and held stable appears on gpio_o after edge DebounceCycles+1. With DebounceCycles=1 that is edge 2.
- Glitch rejection: a new level held for fewer than DebounceCycles cycles at sync1 never reaches gpio_o.
- Bits are fully independent. Simultaneous changes on several bits are accepted in the same cycle if their stability windows coincide.
- gpio_o is glitch-free: it comes from registers only.
- Edge and event logic (macro only):
  - rise_o[i] / fall_o[i] are registered. They pulse high for exactly one cycle, the cycle after gpio_o[i] changes.
  - Event set/clear: event_o[i] <= (event_o[i] & ~event_clr_i[i]) | rise_o[i] | fall_o[i]. Set wins over a clear in the same cycle.
  - irq_o is registered: irq_o <= |(event_o & irq_en_i). It lags event_o by 1 cycle.
  - Changing irq_en_i only affects irq_o; event_o is unchanged.

Optional Feature:
- Macro: GPIO_DEBOUNCE_EVENTS_EN
- Defined: rise_o, fall_o, event_o and irq_o behave as above.
- Undefined:
  - rise_o, fall_o, event_o and irq_o are tied to 0.
  - event_clr_i and irq_en_i are ignored.
  - No event or edge flops are instantiated.
  - Sync and debounce behaviour is identical in both builds.

Test Plan:
- Basic debounce (DebounceCycles=4): reset, then set gpio_i=13'h0001 and hold -> gpio_o stays 0 through edge 4, becomes 13'h0001 after edge 5. With the macro, rise_o[0] pulses 1 cycle later and event_o[0]=1.
- Bounce rejection (DebounceCycles=4): toggle gpio_i[3] 1,0,1,0 with 2-cycle phases, then hold 1 -> gpio_o[3] rises only 6 cycles after the final 0->1 sample. No pulse on rise_o or fall_o during the bouncing.
- Independent bits: gpio_i[12] rises at cycle 0 and gpio_i[5] at cycle 2 -> gpio_o[12] and gpio_o[5] update exactly 2 cycles apart. Release gpio_i[12] -> fall_o[12] pulses and gpio_o[5] stays 1.
- Reset mid-count: assert rst_sys_i asynchronously while cnt[0]=2 -> gpio_o, event_o and irq_o go 0 immediately without waiting for a clock. After release, the full DebounceCycles+2 latency is required again.
- Event/IRQ (macro): irq_en_i=13'h0010, bit 4 rises -> irq_o=1 one cycle after event_o[4]. Strobe event_clr_i[4] -> event_o[4]=0 and irq_o=0 next cycle. Strobe event_clr_i[4] in the same cycle as fall_o[4] -> event_o[4] remains 1.
- Macro off: repeat the basic debounce test -> gpio_o timing is identical; rise_o, fall_o, event_o and irq_o stay 0 throughout.

Source files
------------

// File: rtl/gpio_debounce.sv
// Switch input conditioning ahead of sonata_system gp_i.
// Each bit passes through a 2-flop synchroniser and then a stability counter;
// a new level is only accepted after DebounceCycles consecutive stable cycles.
//
// Optional feature macro: GPIO_DEBOUNCE_EVENTS_EN
//   Defined   : registered rise/fall pulses, sticky event flags and a level irq.
//   Undefined : rise_o, fall_o, event_o and irq_o are tied to 0 and no edge or
//               event flops exist; event_clr_i and irq_en_i are ignored.
module gpio_debounce #(
  parameter int unsigned Width          = 13,
  parameter int unsigned DebounceCycles = 500000,
  parameter int unsigned CntWidth       = 24
) (
  input  logic             clk_sys_i,
  input  logic             rst_sys_i,
  input  logic [Width-1:0] gpio_i,
  output logic [Width-1:0] gpio_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o,
  output logic [Width-1:0] event_o,
  input  logic [Width-1:0] event_clr_i,
  input  logic [Width-1:0] irq_en_i,
  output logic             irq_o
);

  // Terminal count: the cycle on which a differing level is accepted.
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(DebounceCycles - 1);

  // Reject parameter sets where the counter could not hold the terminal count.
  if (DebounceCycles < 1 || (64'(1) << CntWidth) <= 64'(DebounceCycles)) begin : gen_bad_param
    $error("gpio_debounce: DebounceCycles must be >= 1 and < 2**CntWidth");
  end

  logic [Width-1:0]    sync0;
  logic [Width-1:0]    sync1;
  logic [CntWidth-1:0] cnt      [Width];
  logic [CntWidth-1:0] cnt_next [Width];
  logic [Width-1:0]    level_next;

  // Two-flop synchroniser; only sync1 is used downstream.
  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      sync0 <= '0;
      sync1 <= '0;
    end else begin
      sync0 <= gpio_i;
      sync1 <= sync0;
    end
  end

  // Per-bit stability counter: any return to the accepted level restarts the
  // window, so the counter is cleared before it could ever reach DebounceCycles.
  always_comb begin
    level_next = gpio_o;
    for (int i = 0; i < Width; i++) begin
      cnt_next[i] = cnt[i];
      if (sync1[i] == gpio_o[i]) begin
        cnt_next[i] = '0;
      end else if (cnt[i] == CntMax) begin
        level_next[i] = sync1[i];
        cnt_next[i]   = '0;
      end else begin
        cnt_next[i] = cnt[i] + CntWidth'(1);
      end
    end
  end

  // Counter and accepted-level registers; gpio_o comes straight from flops.
  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      gpio_o <= '0;
      for (int i = 0; i < Width; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      gpio_o <= level_next;
      for (int i = 0; i < Width; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

`ifdef GPIO_DEBOUNCE_EVENTS_EN
  // Previous accepted level, so edge pulses land the cycle after gpio_o changes.
  logic [Width-1:0] gpio_prev;

  // Edge pulses, sticky events (a set beats a same-cycle clear) and the irq.
  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      gpio_prev <= '0;
      rise_o    <= '0;
      fall_o    <= '0;
      event_o   <= '0;
      irq_o     <= 1'b0;
    end else begin
      gpio_prev <= gpio_o;
      rise_o    <= gpio_o & ~gpio_prev;
      fall_o    <= ~gpio_o & gpio_prev;
      event_o   <= (event_o & ~event_clr_i) | rise_o | fall_o;
      irq_o     <= |(event_o & irq_en_i);
    end
  end
`else
  // Event logic absent: outputs held low, control inputs deliberately unused.
  logic unused_event_inputs;
  assign unused_event_inputs = ^{event_clr_i, irq_en_i};
  assign rise_o  = '0;
  assign fall_o  = '0;
  assign event_o = '0;
  assign irq_o   = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_debounce.sv
// Self-checking bench for gpio_debounce with DebounceCycles=4.
// Vectors: inputs driven before a clock edge, outputs compared 1 ns after it.
// Works in both builds; event expectations collapse to 0 without the macro.
module tb_gpio_debounce;

  localparam int unsigned W = 13;

  logic         clk_sys_i;
  logic         rst_sys_i;
  logic [W-1:0] gpio_i;
  logic [W-1:0] gpio_o;
  logic [W-1:0] rise_o;
  logic [W-1:0] fall_o;
  logic [W-1:0] event_o;
  logic [W-1:0] event_clr_i;
  logic [W-1:0] irq_en_i;
  logic         irq_o;

  gpio_debounce #(
    .Width          (W),
    .DebounceCycles (4),
    .CntWidth       (24)
  ) dut (
    .clk_sys_i   (clk_sys_i),
    .rst_sys_i   (rst_sys_i),
    .gpio_i      (gpio_i),
    .gpio_o      (gpio_o),
    .rise_o      (rise_o),
    .fall_o      (fall_o),
    .event_o     (event_o),
    .event_clr_i (event_clr_i),
    .irq_en_i    (irq_en_i),
    .irq_o       (irq_o)
  );

  initial clk_sys_i = 1'b0;
  always #5 clk_sys_i = ~clk_sys_i;

  typedef struct {
    logic [W-1:0] gi;
    logic [W-1:0] clr;
    logic [W-1:0] en;
    logic [W-1:0] eg;
    logic [W-1:0] er;
    logic [W-1:0] ef;
    logic [W-1:0] ee;
    logic         ei;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

`ifdef GPIO_DEBOUNCE_EVENTS_EN
  localparam bit EvEn = 1'b1;
`else
  localparam bit EvEn = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Append one vector; event-side expectations are zero without the macro.
  task automatic add(input logic [W-1:0] gi, input logic [W-1:0] clr, input logic [W-1:0] en,
                     input logic [W-1:0] eg, input logic [W-1:0] er, input logic [W-1:0] ef,
                     input logic [W-1:0] ee, input logic ei);
    vec_t v;
    v.gi  = gi;
    v.clr = clr;
    v.en  = en;
    v.eg  = eg;
    v.er  = EvEn ? er : '0;
    v.ef  = EvEn ? ef : '0;
    v.ee  = EvEn ? ee : '0;
    v.ei  = EvEn ? ei : 1'b0;
    vecs.push_back(v);
  endtask

  task automatic compare_outputs(input string tag, input vec_t e);
    check({tag, " gpio_o"},  32'(gpio_o),  32'(e.eg));
    check({tag, " rise_o"},  32'(rise_o),  32'(e.er));
    check({tag, " fall_o"},  32'(fall_o),  32'(e.ef));
    check({tag, " event_o"}, 32'(event_o), 32'(e.ee));
    check({tag, " irq_o"},   32'(irq_o),   32'(e.ei));
  endtask

  // Apply the vector table; expectations go through the scoreboard queue.
  task automatic run_vecs(input string name);
    vec_t e;
    for (int k = 0; k < vecs.size(); k++) begin
      gpio_i      = vecs[k].gi;
      event_clr_i = vecs[k].clr;
      irq_en_i    = vecs[k].en;
      exp_q.push_back(vecs[k]);
      @(posedge clk_sys_i);
      #1;
      e = exp_q.pop_front();
      compare_outputs($sformatf("%s k=%0d", name, k), e);
    end
    vecs.delete();
    event_clr_i = '0;
  endtask

  task automatic do_reset();
    vec_t z;
    z = '{default: '0};
    gpio_i      = '0;
    event_clr_i = '0;
    irq_en_i    = '0;
    rst_sys_i   = 1'b1;
    repeat (2) @(posedge clk_sys_i);
    #1;
    compare_outputs("reset", z);
    rst_sys_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t z;
    z = '{default: '0};
    rst_sys_i   = 1'b0;
    gpio_i      = '0;
    event_clr_i = '0;
    irq_en_i    = '0;

    // Basic: bit 0 held high, accepted after edge 5.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      add(13'h0001, '0, '0,
          (k >= 5) ? 13'h0001 : 13'h0,
          (k == 6) ? 13'h0001 : 13'h0,
          '0,
          (k >= 7) ? 13'h0001 : 13'h0,
          1'b0);
    end
    run_vecs("basic");

    // Bounce on bit 3: 1,1,0,0,1,1,0,0 then held 1; last rise sampled at k=8.
    do_reset();
    for (int k = 0; k < 16; k++) begin
      logic in3;
      in3 = (k >= 8) || (k % 4 < 2);
      add({9'b0, in3, 3'b0}, '0, '0,
          (k >= 13) ? 13'h0008 : 13'h0,
          (k == 14) ? 13'h0008 : 13'h0,
          '0,
          (k >= 15) ? 13'h0008 : 13'h0,
          1'b0);
    end
    run_vecs("bounce");

    // Independent bits: bit 12 at k=0, bit 5 at k=2, bit 12 released at k=9.
    do_reset();
    for (int k = 0; k < 17; k++) begin
      logic [W-1:0] gi, eg, er, ee;
      gi = (k < 2) ? 13'h1000 : (k < 9) ? 13'h1020 : 13'h0020;
      eg = (k < 5) ? 13'h0 : (k < 7) ? 13'h1000 : (k < 14) ? 13'h1020 : 13'h0020;
      er = (k == 6) ? 13'h1000 : (k == 8) ? 13'h0020 : 13'h0;
      ee = (k < 7) ? 13'h0 : (k < 9) ? 13'h1000 : 13'h1020;
      add(gi, '0, '0, eg, er, (k == 15) ? 13'h1000 : 13'h0, ee, 1'b0);
    end
    run_vecs("indep");

    // Reset mid-count: bit 1 settled with irq, then bit 0 counting (cnt=2).
    do_reset();
    for (int k = 0; k < 9; k++) begin
      add(13'h0002, '0, 13'h0002,
          (k >= 5) ? 13'h0002 : 13'h0,
          (k == 6) ? 13'h0002 : 13'h0,
          '0,
          (k >= 7) ? 13'h0002 : 13'h0,
          k >= 8);
    end
    for (int k = 0; k < 4; k++) begin
      add(13'h0003, '0, 13'h0002, 13'h0002, '0, '0, 13'h0002, 1'b1);
    end
    run_vecs("midpre");
    gpio_i    = 13'h0003;
    irq_en_i  = 13'h0002;
    rst_sys_i = 1'b1;
    #1;
    compare_outputs("async_reset", z);
    #1;
    rst_sys_i = 1'b0;
    for (int k = 0; k < 7; k++) begin
      add(13'h0003, '0, 13'h0002,
          (k >= 5) ? 13'h0003 : 13'h0,
          (k == 6) ? 13'h0003 : 13'h0,
          '0, '0, 1'b0);
    end
    run_vecs("midpost");

    // Event/irq on bit 4: clear at k=9, fall at k=17 with clear at k=18.
    do_reset();
    for (int k = 0; k < 23; k++) begin
      logic [W-1:0] clr, ee, en;
      logic         ei;
      clr = (k == 9 || k == 18) ? 13'h0010 : 13'h0;
      en  = (k >= 21) ? 13'h0 : 13'h0010;
      ee  = ((k >= 7 && k <= 8) || k >= 18) ? 13'h0010 : 13'h0;
      ei  = (k == 8 || k == 9 || (k >= 19 && k <= 20));
      add((k < 11) ? 13'h0010 : 13'h0, clr, en,
          (k >= 5 && k < 16) ? 13'h0010 : 13'h0,
          (k == 6) ? 13'h0010 : 13'h0,
          (k == 17) ? 13'h0010 : 13'h0,
          ee, ei);
    end
    run_vecs("event");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
